id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/reg_file.sv | 33 +++
 rtl/id_stage.sv | 151 +++++++++++++++
 tb/tb_id_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared decode constants: opcodes, R-type funct codes, ALU operation
// encoding and the control-word layout used by the decode stage.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  // Bit positions of the control word, MSB first.
  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_DST    = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_JUMP       = 1;
  localparam int CTRL_ZERO_EXT   = 0;

  // Field order matches the bit positions above.
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic zero_ext;
  } ctrl_t;

  // Instructions that actually read rt as a source operand.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: $0 hard-wired to zero, synchronous write,
// combinational read with write-through of the same-cycle write-back.
module reg_file
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] regs [32];

  // Register array update; reset wins over any pending write-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign rs_data = (rs_addr == 5'd0) ? 32'd0 :
                   (wb_en && (wb_addr == rs_addr)) ? wb_data : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0) ? 32'd0 :
                   (wb_en && (wb_addr == rt_addr)) ? wb_data : regs[rt_addr];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID pipeline register, combinational decode,
// load-use hazard stall, flush handling and register-file operand read.
module id_stage
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [8:0]  ctrl,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] jump_target,
  output logic        illegal
);

  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        stall;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  ctrl_t       ctrl_dec;
  alu_op_e     alu_dec;
  logic        legal;

  assign opcode = id_instr[31:26];
  assign funct  = id_instr[5:0];
  assign imm    = id_instr[15:0];
  assign out_rs = id_instr[25:21];
  assign out_rt = id_instr[20:16];
  assign out_rd = id_instr[15:11];

  // Load-use hazard: the load result is not yet available to this instruction.
  always_comb begin
    stall = 1'b0;
    if (id_valid && ex_mem_read && (ex_rt != 5'd0)) begin
      stall = (ex_rt == out_rs) || (reads_rt(opcode) && (ex_rt == out_rt));
    end
  end

  assign in_ready  = !stall;
  assign out_valid = id_valid && !stall;

  // IF/ID register; flush drops the held instruction even when stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (in_ready) begin
      id_valid <= in_valid;
      id_instr <= in_instr;
      id_pc    <= in_pc;
    end
  end

  // Opcode/funct decode; anything unrecognised leaves a zero control word.
  always_comb begin
    ctrl_dec = '0;
    alu_dec  = ALU_ADD;
    legal    = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        unique case (funct)
          FN_ADD:  alu_dec = ALU_ADD;
          FN_SUB:  alu_dec = ALU_SUB;
          FN_AND:  alu_dec = ALU_AND;
          FN_OR:   alu_dec = ALU_OR;
          FN_SLT:  alu_dec = ALU_SLT;
          default: legal   = 1'b0;
        endcase
        ctrl_dec.reg_dst   = legal;
        ctrl_dec.reg_write = legal;
      end
      OP_LW: begin
        legal               = 1'b1;
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
      end
      OP_SW: begin
        legal              = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        legal           = 1'b1;
        ctrl_dec.branch = 1'b1;
        alu_dec         = ALU_SUB;
      end
      OP_J: begin
        legal         = 1'b1;
        ctrl_dec.jump = 1'b1;
      end
      OP_ADDI: begin
        legal              = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
      end
      OP_ORI: begin
        legal              = 1'b1;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.zero_ext  = 1'b1;
        alu_dec            = ALU_OR;
      end
      default: legal = 1'b0;
    endcase
  end

  assign ctrl        = out_valid ? ctrl_dec : '0;
  assign alu_ctrl    = alu_dec;
  assign illegal     = id_valid && !legal;
  assign imm_ext     = ctrl_dec.zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign out_pc      = id_pc;
  assign jump_target = {id_pc[31:28], id_instr[25:0], 2'b00};

  reg_file u_reg_file (
    .clock   (clock),
    .reset   (reset),
    .rs_addr (out_rs),
    .rt_addr (out_rt),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized
// traffic compared against a behavioural pipeline/register model.
module tb_id_stage;

  logic        clock = 1'b0;
  logic        reset, in_valid, flush, ex_mem_read, wb_en;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  ex_rt, wb_addr;
  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, rs_data, rt_data, imm_ext, jump_target;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [8:0]  ctrl;
  logic [3:0]  alu_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic        m_valid;
  logic [31:0] m_instr, m_pc;
  logic [31:0] m_regs [32];

  always #5 clock = ~clock;

  id_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc(in_pc), .in_ready(in_ready), .flush(flush), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_pc(out_pc), .rs_data(rs_data), .rt_data(rt_data),
    .imm_ext(imm_ext), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .ctrl(ctrl), .alu_ctrl(alu_ctrl), .jump_target(jump_target), .illegal(illegal)
  );

  // ---------------- reference model ----------------
  function automatic logic m_legal(input logic [31:0] ins);
    case (ins[31:26])
      6'd0:   return ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Control word {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, zero_ext}
  function automatic logic [8:0] m_ctrl(input logic [31:0] ins);
    if (!m_legal(ins)) return 9'b0;
    case (ins[31:26])
      6'd0:    return 9'b1_0_0_1_0_0_0_0_0;
      6'h23:   return 9'b0_1_1_1_1_0_0_0_0;
      6'h2B:   return 9'b0_1_0_0_0_1_0_0_0;
      6'h04:   return 9'b0_0_0_0_0_0_1_0_0;
      6'h02:   return 9'b0_0_0_0_0_0_0_1_0;
      6'h08:   return 9'b0_1_0_1_0_0_0_0_0;
      default: return 9'b0_1_0_1_0_0_0_0_1;
    endcase
  endfunction

  function automatic logic [3:0] m_alu(input logic [31:0] ins);
    if (!m_legal(ins)) return 4'd0;
    if (ins[31:26] == 6'h04) return 4'd1;
    if (ins[31:26] == 6'h0D) return 4'd3;
    if (ins[31:26] != 6'd0) return 4'd0;
    case (ins[5:0])
      6'h22:   return 4'd1;
      6'h24:   return 4'd2;
      6'h25:   return 4'd3;
      6'h2A:   return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    int v;
    v = int'(ins[15:0]);
    if (ins[31:26] != 6'h0D && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic m_stall();
    logic [4:0] rs, rt;
    logic uses_rt;
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    uses_rt = (m_instr[31:26] == 6'd0) || (m_instr[31:26] == 6'h2B) || (m_instr[31:26] == 6'h04);
    return m_valid && ex_mem_read && ex_rt != 0 && (ex_rt == rs || (uses_rt && ex_rt == rt));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  // Advance model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    logic st;
    st = m_stall();
    if (reset) begin
      m_valid = 0; m_instr = 0; m_pc = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else begin
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (flush) m_valid = 0;
      else if (!st) begin
        m_valid = in_valid; m_instr = in_instr; m_pc = in_pc;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
    ex_mem_read = 0; ex_rt = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 0;
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1; in_valid = 1; in_instr = 32'h00221820; flush = 1; wb_en = 1; wb_addr = 3;
    tick();
    tick();
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0h want 0", out_valid); end
    n_checks++; if (ctrl !== 9'd0) begin n_errors++; $display("FAIL reset_ctrl: got %0h want 0", ctrl); end
    n_checks++; if (illegal !== 1'b0) begin n_errors++; $display("FAIL reset_illegal: got %0h want 0", illegal); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
  endtask

  task automatic test_add();
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    issue(32'h00221820, 32'h0000_0040);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL add_out_valid: got %0h want 1", out_valid); end
    n_checks++; if (rs_data !== 32'd5) begin n_errors++; $display("FAIL add_rs_data: got %0h want 5", rs_data); end
    n_checks++; if (rt_data !== 32'd7) begin n_errors++; $display("FAIL add_rt_data: got %0h want 7", rt_data); end
    n_checks++; if (out_rd !== 5'd3) begin n_errors++; $display("FAIL add_out_rd: got %0d want 3", out_rd); end
    n_checks++; if (ctrl !== 9'b1_0_0_1_0_0_0_0_0) begin n_errors++; $display("FAIL add_ctrl: got %b want 100100000", ctrl); end
    n_checks++; if (alu_ctrl !== 4'd0) begin n_errors++; $display("FAIL add_alu: got %0d want 0", alu_ctrl); end
    n_checks++; if (out_pc !== 32'h40) begin n_errors++; $display("FAIL add_out_pc: got %0h want 40", out_pc); end
  endtask

  task automatic test_load_use();
    issue(32'h00432020, 32'h0000_0100);
    ex_mem_read = 1; ex_rt = 5'd2;
    in_valid = 1; in_instr = 32'h00221820; in_pc = 32'h0000_0104;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL hazard_in_ready: got %0h want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL hazard_bubble: got %0h want 0", out_valid); end
    n_checks++; if (ctrl !== 9'd0) begin n_errors++; $display("FAIL hazard_ctrl: got %0h want 0", ctrl); end
    tick();
    ex_mem_read = 0; ex_rt = 0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_rd !== 5'd4 || out_pc !== 32'h100) begin
      n_errors++; $display("FAIL hazard_resume: got valid=%0h rd=%0d pc=%0h want 1/4/100", out_valid, out_rd, out_pc); end
    tick();
    in_valid = 0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_pc !== 32'h104) begin
      n_errors++; $display("FAIL hazard_next: got valid=%0h rd=%0d pc=%0h want 1/3/104", out_valid, out_rd, out_pc); end
  endtask

  task automatic test_write_through();
    issue(32'h00802020, 32'h0000_0200);
    wb_en = 1; wb_addr = 5'd4; wb_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (rs_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wt_same_cycle: got %0h want deadbeef", rs_data); end
    n_checks++; if (rt_data !== 32'd0) begin n_errors++; $display("FAIL wt_rt_zero: got %0h want 0", rt_data); end
    tick();
    wb_en = 0;
    #1;
    n_checks++; if (rs_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wt_stored: got %0h want deadbeef", rs_data); end
  endtask

  task automatic test_zero_reg_imm();
    wb_write(5'd0, 32'h1234);
    issue(32'h00001020, 32'h0000_0300);
    n_checks++; if (rs_data !== 32'd0) begin n_errors++; $display("FAIL zero_reg_read: got %0h want 0", rs_data); end
    issue(32'h2001FFFF, 32'h0000_0304);
    n_checks++; if (imm_ext !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL addi_imm: got %0h want ffffffff", imm_ext); end
    n_checks++; if (ctrl[7] !== 1'b1 || ctrl !== 9'b0_1_0_1_0_0_0_0_0) begin n_errors++; $display("FAIL addi_ctrl: got %b want 010100000", ctrl); end
    issue(32'h3401FFFF, 32'h0000_0308);
    n_checks++; if (imm_ext !== 32'h0000FFFF) begin n_errors++; $display("FAIL ori_imm: got %0h want 0000ffff", imm_ext); end
    n_checks++; if (alu_ctrl !== 4'd3 || ctrl[0] !== 1'b1) begin n_errors++; $display("FAIL ori_decode: got alu=%0d ctrl=%b want 3/zero_ext", alu_ctrl, ctrl); end
  endtask

  task automatic test_flush_stall();
    issue(32'h00432020, 32'h0000_0400);
    ex_mem_read = 1; ex_rt = 5'd2; flush = 1;
    in_valid = 1; in_instr = 32'h00221820; in_pc = 32'h404;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_stall_ready: got %0h want 0", in_ready); end
    tick();
    flush = 0; ex_mem_read = 0; ex_rt = 0; in_valid = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_out_valid: got %0h want 0", out_valid); end
    n_checks++; if (ctrl !== 9'd0) begin n_errors++; $display("FAIL flush_ctrl: got %0h want 0", ctrl); end
  endtask

  task automatic test_illegal_reset();
    issue(32'hFC000000, 32'h0000_0500);
    n_checks++; if (illegal !== 1'b1) begin n_errors++; $display("FAIL illegal_op: got %0h want 1", illegal); end
    n_checks++; if (ctrl !== 9'd0) begin n_errors++; $display("FAIL illegal_ctrl: got %0h want 0", ctrl); end
    issue(32'h00221821, 32'h0000_0504);
    n_checks++; if (illegal !== 1'b1 || ctrl !== 9'd0) begin n_errors++; $display("FAIL illegal_funct: got ill=%0h ctrl=%0h want 1/0", illegal, ctrl); end
    wb_write(5'd9, 32'hCAFE0001);
    reset = 1; wb_en = 1; wb_addr = 5'd10; wb_data = 32'h55; flush = 1;
    ex_mem_read = 1; ex_rt = 5'd1; in_valid = 1; in_instr = 32'h00221820;
    tick();
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 1'b0 || illegal !== 1'b0 || ctrl !== 9'd0) begin
      n_errors++; $display("FAIL midreset_outputs: got v=%0h ill=%0h ctrl=%0h want 0/0/0", out_valid, illegal, ctrl); end
    for (int i = 1; i < 32; i += 2) begin
      issue({6'd0, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'h20}, 32'h600 + 32'(i));
      n_checks++; if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
        n_errors++; $display("FAIL midreset_reg%0d: got rs=%0h rt=%0h want 0/0", i, rs_data, rt_data); end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    logic [5:0] fns [7];
    logic [5:0] op, fn;
    logic [31:0] ins;
    logic [8:0] e_ctrl;
    logic e_ovalid;
    ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0D, 6'h3F, 6'h05};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21, 6'h00};
    for (int c = 0; c < 600; c++) begin
      op = ops[$urandom_range(0, 9)];
      fn = fns[$urandom_range(0, 6)];
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom), (op == 6'h00) ? fn : 6'($urandom)};
      reset       = ($urandom_range(0, 59) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_instr    = ins;
      in_pc       = $urandom;
      flush       = ($urandom_range(0, 9) == 0);
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rt       = 5'($urandom_range(0, 7));
      wb_en       = $urandom_range(0, 1);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      #1;
      e_ovalid = m_valid && !m_stall();
      e_ctrl   = e_ovalid ? m_ctrl(m_instr) : 9'd0;
      n_checks++; if (in_ready !== !m_stall()) begin n_errors++; $display("FAIL rnd_in_ready c%0d: got %0h want %0h", c, in_ready, !m_stall()); end
      n_checks++; if (out_valid !== e_ovalid) begin n_errors++; $display("FAIL rnd_out_valid c%0d: got %0h want %0h", c, out_valid, e_ovalid); end
      n_checks++; if (ctrl !== e_ctrl) begin n_errors++; $display("FAIL rnd_ctrl c%0d: got %b want %b", c, ctrl, e_ctrl); end
      n_checks++; if (illegal !== (m_valid && !m_legal(m_instr))) begin n_errors++; $display("FAIL rnd_illegal c%0d: got %0h", c, illegal); end
      n_checks++; if (rs_data !== m_read(m_instr[25:21])) begin n_errors++; $display("FAIL rnd_rs_data c%0d: got %0h want %0h", c, rs_data, m_read(m_instr[25:21])); end
      n_checks++; if (rt_data !== m_read(m_instr[20:16])) begin n_errors++; $display("FAIL rnd_rt_data c%0d: got %0h want %0h", c, rt_data, m_read(m_instr[20:16])); end
      n_checks++; if (imm_ext !== m_imm(m_instr)) begin n_errors++; $display("FAIL rnd_imm c%0d: got %0h want %0h", c, imm_ext, m_imm(m_instr)); end
      n_checks++; if (alu_ctrl !== m_alu(m_instr)) begin n_errors++; $display("FAIL rnd_alu c%0d: got %0d want %0d", c, alu_ctrl, m_alu(m_instr)); end
      n_checks++; if (out_pc !== m_pc || out_rd !== m_instr[15:11] || out_rs !== m_instr[25:21] || out_rt !== m_instr[20:16]) begin
        n_errors++; $display("FAIL rnd_fields c%0d: got pc=%0h rd=%0d want pc=%0h rd=%0d", c, out_pc, out_rd, m_pc, m_instr[15:11]); end
      n_checks++; if (jump_target !== ((m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4))) begin
        n_errors++; $display("FAIL rnd_jump_target c%0d: got %0h", c, jump_target); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_valid = 0; m_instr = 0; m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_add();
    test_load_use();
    test_write_through();
    test_zero_reg_imm();
    test_flush_stall();
    test_illegal_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
